dma_wreq_arb: RTL and testbench
===============================

# dma_wreq_arb

Packet-granular arbiter that shares the single aligned write-request path of the DMA write engine among `CHNL_NUM` requesters (doorbell/queue engines, completion writers, interrupt generator). It sits directly upstream of the write-request splitter and drives its aligned valid/last/user/data/ready interface. Within a packet it is a pure combinational mux; grants change only on packet boundaries, so beats of different requests never interleave.

## Interface
- `CHNL_NUM`, 4: number of requesters, 2..8.
- `CHNL_W`, 2: grant index width, `$clog2(CHNL_NUM)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in `CHNL_NUM`: per-channel beat valid.
- `s_last` in `CHNL_NUM`: per-channel last beat of the request.
- `s_user` in `CHNL_NUM*AXIS_TUSER_W`: per-channel tuser, same layout as the aligned request (REQ_TYPE 107:104, addr 95:32, DW length 18:8, BEs 7:0), valid on the first beat.
- `s_data` in `CHNL_NUM*DMA_DATA_W`: per-channel data.
- `s_ready` out `CHNL_NUM`: per-channel ready.
- `m_valid` out 1, `m_last` out 1, `m_user` out `AXIS_TUSER_W`, `m_data` out `DMA_DATA_W`: to splitter aligned input.
- `m_ready` in 1: from splitter.
- `grant_idx` out `CHNL_W`: currently owning channel, for debug/APB.
- `busy` out 1: high while in LOCK.

## Operation
- FSM states: IDLE, LOCK.
- IDLE: if any `s_valid`, select a winner round-robin starting at `rr_ptr`. Register `grant_idx` as the winner and `rr_ptr` as the winner+1 (mod `CHNL_NUM`), then go to LOCK. Outputs are not driven in IDLE.
- LOCK: `m_valid`, `m_last`, `m_user` and `m_data` are the granted channel's signals. `s_ready[grant_idx]` is `m_ready`; every other `s_ready` bit is 0.
- On `m_valid & m_ready & m_last`, go to IDLE. Re-arbitration happens in the next cycle.
- Granted channel drops `s_valid` mid-packet: `m_valid` drops with it and the grant is held until its last beat.
- `m_ready` low: all signals hold and no state changes.
- Single-beat packet (`s_last` on the first beat): LOCK lasts exactly until that beat is accepted.
- `m_user` is forwarded on every beat. The splitter samples it on the first beat only.
- Non-winning channels must keep valid/data stable; they are not acknowledged.

## Timing
- Reset values: FSM IDLE, `grant_idx`=0, `rr_ptr`=0, `busy`=0, `m_valid`=0, `m_last`=0, `m_user`=0, `m_data`=0, `s_ready`=0.
- Latency: `s_valid` rising in IDLE gives `m_valid` in the next cycle (1 clk).
- Steady state: 1 beat per cycle within a packet.
- One bubble cycle (IDLE) between consecutive packets.
- Reset asserted mid-packet: return to reset values immediately. The partial packet is abandoned; the splitter is reset by the same `rst_n`.

## Configuration
- `DMA_WREQ_ARB_HIPRI_EN` defined: channel 0 (interrupt requester) has strict priority. Whenever `s_valid[0]` is high in IDLE it wins, and `rr_ptr` is not updated. Channels 1..N-1 round-robin among themselves when channel 0 is idle.
- Undefined: plain round-robin over all channels, channel 0 included.

## Structure
- Shared DMA defines package/header holds `AXIS_TUSER_W`, `DMA_DATA_W`, REQ_TYPE codes (`DMA_INT_REQ`) and the IDLE/LOCK one-hot constants.
- One sub-module: `rr_arbiter`, a combinational round-robin priority picker taking `req[CHNL_NUM]` and `ptr[CHNL_W]` and producing `gnt_idx` and `gnt_vld`. The FSM, mux and pointer registers live in the top.

## Test plan
- Single channel 2 sends a 4-beat request with `m_ready`=1 -> `m_valid` one cycle after `s_valid`; 4 beats out consecutively; `m_last` on the 4th; `grant_idx`=2; `rr_ptr`=3 afterwards.
- All 4 channels hold valid continuously, 1-beat packets each -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Channel 1 mid-packet with `m_ready` toggling 1,0,0,1 and channel 3 valid -> no channel-3 beat appears before channel 1's `m_last` is accepted; `s_ready[3]` stays 0 throughout.
- Channel 0 drops `s_valid` for 2 cycles mid-packet -> `m_valid` is 0 for those 2 cycles, `grant_idx` is unchanged and the packet completes.
- `rst_n` pulsed during beat 2 of a 5-beat packet -> all outputs return to reset values the same cycle; the next request is arbitrated from `rr_ptr`=0.
- With `DMA_WREQ_ARB_HIPRI_EN`, channels 0 and 2 are valid repeatedly -> channel 0 wins every IDLE in which it is valid; channel 2 wins only when `s_valid[0]` is low.

Source files
------------

// File: rtl/dma_wreq_arb_pkg.sv
// Shared DMA write-path definitions: tuser/data widths, request type codes,
// tuser field positions and the arbiter's one-hot state encoding.
package dma_wreq_arb_pkg;

  localparam int AXIS_TUSER_W = 108;
  localparam int DMA_DATA_W   = 64;

  // REQ_TYPE codes carried in tuser[107:104]
  localparam logic [3:0] DMA_MEM_WR  = 4'h1;
  localparam logic [3:0] DMA_INT_REQ = 4'h4;

  // tuser field positions of the aligned request
  localparam int USER_TYPE_LSB = 104;
  localparam int USER_ADDR_LSB = 32;
  localparam int USER_LEN_LSB  = 8;
  localparam int USER_BE_LSB   = 0;

  // One-hot arbiter states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b01,
    ARB_LOCK = 2'b10
  } arb_state_e;

endpackage

// File: rtl/dma_wreq_arb_rr_arbiter.sv
// Combinational round-robin priority picker: scans req starting at ptr and
// returns the first requesting index.
module rr_arbiter #(
  parameter int CHNL_NUM = 4,
  parameter int CHNL_W   = 2
) (
  input  logic [CHNL_NUM-1:0] req,
  input  logic [CHNL_W-1:0]   ptr,
  output logic [CHNL_W-1:0]   gnt_idx,
  output logic                gnt_vld
);

  int k;

  // First requester at or after ptr, wrapping modulo CHNL_NUM
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = 0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      k = (int'(ptr) + i) % CHNL_NUM;
      if (!gnt_vld && req[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = k[CHNL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_wreq_arb.sv
// Packet-granular arbiter in front of the DMA write-request splitter.
// Grants change only on packet boundaries; inside a packet the granted
// channel is muxed straight through.
// Build option: DMA_WREQ_ARB_HIPRI_EN gives channel 0 (interrupt requester)
// strict priority; channels 1..N-1 round-robin among themselves.
//
// state    | meaning
// ARB_IDLE | no owner; pick a winner from the valid channels
// ARB_LOCK | grant_idx owns the path until its last beat is accepted
module dma_wreq_arb
  import dma_wreq_arb_pkg::*;
#(
  parameter int CHNL_NUM = 4,
  parameter int CHNL_W   = $clog2(CHNL_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHNL_NUM-1:0]            s_valid,
  input  logic [CHNL_NUM-1:0]            s_last,
  input  logic [CHNL_NUM*AXIS_TUSER_W-1:0] s_user,
  input  logic [CHNL_NUM*DMA_DATA_W-1:0]   s_data,
  output logic [CHNL_NUM-1:0]            s_ready,
  output logic                           m_valid,
  output logic                           m_last,
  output logic [AXIS_TUSER_W-1:0]        m_user,
  output logic [DMA_DATA_W-1:0]          m_data,
  input  logic                           m_ready,
  output logic [CHNL_W-1:0]              grant_idx,
  output logic                           busy
);

  arb_state_e          state, state_nxt;
  logic [CHNL_W-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [CHNL_NUM-1:0] arb_req;
  logic [CHNL_W-1:0]   arb_idx;
  logic                arb_vld;
  logic                hipri_win;

`ifdef DMA_WREQ_ARB_HIPRI_EN
  // Channel 0 bypasses the round-robin and never moves the pointer
  assign hipri_win = s_valid[0];
  assign arb_req   = {s_valid[CHNL_NUM-1:1], 1'b0};
`else
  assign hipri_win = 1'b0;
  assign arb_req   = s_valid;
`endif

  rr_arbiter #(
    .CHNL_NUM (CHNL_NUM),
    .CHNL_W   (CHNL_W)
  ) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign busy = (state == ARB_LOCK);

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  // Next state: arbitrate in IDLE, release on accepted last beat
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_idx;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (hipri_win) begin
          state_nxt = ARB_LOCK;
          grant_nxt = '0;
        end else if (arb_vld) begin
          state_nxt  = ARB_LOCK;
          grant_nxt  = arb_idx;
          rr_ptr_nxt = (arb_idx == CHNL_W'(CHNL_NUM - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ARB_LOCK: begin
        if (m_valid && m_ready && m_last) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Datapath mux: only the granted channel is visible and acknowledged
  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_user  = '0;
    m_data  = '0;
    s_ready = '0;
    if (state == ARB_LOCK) begin
      m_valid            = s_valid[grant_idx];
      m_last             = s_last[grant_idx];
      m_user             = s_user[int'(grant_idx)*AXIS_TUSER_W +: AXIS_TUSER_W];
      m_data             = s_data[int'(grant_idx)*DMA_DATA_W +: DMA_DATA_W];
      s_ready[grant_idx] = m_ready;
    end
  end

endmodule

// File: tb/tb_dma_wreq_arb.sv
// Self-checking bench for dma_wreq_arb. Per-channel source queues drive the
// inputs; expected beats are pushed to a scoreboard in the order the bench
// expects them to be granted and popped on every m_valid & m_ready.
module tb_dma_wreq_arb;
  import dma_wreq_arb_pkg::*;

  localparam int CN = 4;
  localparam int CW = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [CN-1:0]              s_valid;
  logic [CN-1:0]              s_last;
  logic [CN*AXIS_TUSER_W-1:0] s_user;
  logic [CN*DMA_DATA_W-1:0]   s_data;
  logic [CN-1:0]              s_ready;
  logic                       m_valid;
  logic                       m_last;
  logic [AXIS_TUSER_W-1:0]    m_user;
  logic [DMA_DATA_W-1:0]      m_data;
  logic                       m_ready;
  logic [CW-1:0]              grant_idx;
  logic                       busy;

  dma_wreq_arb #(.CHNL_NUM(CN), .CHNL_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_user    (s_user),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_user    (m_user),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      chan;
    logic [DMA_DATA_W-1:0]   data;
    logic                    last;
    logic [AXIS_TUSER_W-1:0] user;
  } beat_t;

  typedef struct {
    int chan;
    int nbeats;
    int exp_cycles;
  } vec_t;

  beat_t src_q [CN][$];
  beat_t stg_q [CN][$];
  beat_t exp_q [$];
  logic [CN-1:0] en;

  int checks   = 0;
  int failures = 0;
  int pkt_id   = 0;
  int s3_viol  = 0;
  logic s3_watch = 1'b0;
  logic snap_mvalid, snap_busy;
  logic [CW-1:0] snap_grant;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AXIS_TUSER_W-1:0] mk_user(input int chan, input int nb, input int pid);
    logic [AXIS_TUSER_W-1:0] u;
    u = '0;
    u[USER_TYPE_LSB +: 4] = (chan == 0) ? DMA_INT_REQ : DMA_MEM_WR;
    u[USER_ADDR_LSB +: 64] = 64'h1000_0000 + 64'(pid) * 64'h40;
    u[USER_LEN_LSB  +: 11] = 11'(nb);
    u[USER_BE_LSB   +: 8]  = 8'hFF;
    return u;
  endfunction

  task automatic drive();
    for (int c = 0; c < CN; c++) begin
      if (en[c] && src_q[c].size() > 0) begin
        s_valid[c] = 1'b1;
        s_last[c]  = src_q[c][0].last;
        s_data[c*DMA_DATA_W +: DMA_DATA_W]     = src_q[c][0].data;
        s_user[c*AXIS_TUSER_W +: AXIS_TUSER_W] = src_q[c][0].user;
      end else begin
        s_valid[c] = 1'b0;
        s_last[c]  = 1'b0;
        s_data[c*DMA_DATA_W +: DMA_DATA_W]     = '0;
        s_user[c*AXIS_TUSER_W +: AXIS_TUSER_W] = '0;
      end
    end
  endtask

  task automatic load_pkt(input int chan, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.chan = chan;
      b.data = {32'(pkt_id), 16'(chan), 16'(i)};
      b.last = (i == nb - 1);
      b.user = mk_user(chan, nb, pkt_id);
      src_q[chan].push_back(b);
      stg_q[chan].push_back(b);
    end
    pkt_id++;
  endtask

  // Declare the next packet of a channel as the next one expected downstream
  task automatic expect_next(input int chan);
    beat_t b;
    do begin
      b = stg_q[chan].pop_front();
      exp_q.push_back(b);
    end while (!b.last && stg_q[chan].size() > 0);
  endtask

  task automatic cycle();
    logic [CN-1:0] acc;
    beat_t e;
    @(negedge clk);
    acc         = s_valid & s_ready;
    snap_mvalid = m_valid;
    snap_grant  = grant_idx;
    snap_busy   = busy;
    if (s3_watch && s_ready[3]) s3_viol++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected actual=grant %0d data %0h required=no beat", grant_idx, m_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_grant",  128'(grant_idx), 128'(e.chan));
        chk("beat_data",   128'(m_data),    128'(e.data));
        chk("beat_last",   128'(m_last),    128'(e.last));
        chk("beat_user",   128'(m_user),    128'(e.user));
        chk("beat_sready", 128'(s_ready),   128'(CN'(1) << e.chan));
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < CN; c++)
      if (acc[c]) void'(src_q[c].pop_front());
    drive();
  endtask

  task automatic run(input int max, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},    128'(busy),      '0);
    chk({tag, "_mvalid"},  128'(m_valid),   '0);
    chk({tag, "_mlast"},   128'(m_last),    '0);
    chk({tag, "_muser"},   128'(m_user),    '0);
    chk({tag, "_mdata"},   128'(m_data),    '0);
    chk({tag, "_sready"},  128'(s_ready),   '0);
    chk({tag, "_grant"},   128'(grant_idx), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   rp[6];
    int   ord_b[8];
    int   ord_03[2];

    vecs[0] = '{chan: 2, nbeats: 4, exp_cycles: 5};
    vecs[1] = '{chan: 0, nbeats: 1, exp_cycles: 2};
    vecs[2] = '{chan: 3, nbeats: 2, exp_cycles: 3};
    vecs[3] = '{chan: 1, nbeats: 3, exp_cycles: 4};
    rp = '{1, 1, 0, 0, 1, 1};
`ifdef DMA_WREQ_ARB_HIPRI_EN
    ord_b  = '{0, 0, 1, 2, 3, 1, 2, 3};
    ord_03 = '{0, 3};
`else
    ord_b  = '{0, 1, 2, 3, 0, 1, 2, 3};
    ord_03 = '{3, 0};
`endif

    rst_n   = 1'b0;
    m_ready = 1'b1;
    en      = '1;
    s_valid = '0;
    s_last  = '0;
    s_user  = '0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-packet vectors: expected completion time covers 1-cycle
    // arbitration latency plus one beat per cycle
    for (int v = 0; v < 4; v++) begin
      load_pkt(vecs[v].chan, vecs[v].nbeats);
      expect_next(vecs[v].chan);
      drive();
      run(50, n);
      chk($sformatf("vec%0d_cycles", v), 128'(n), 128'(vecs[v].exp_cycles));
      chk($sformatf("vec%0d_idle_after", v), 128'(busy), '0);
    end

    // Pointer after channel 2 is 3: with 0 and 3 pending, 3 wins next
    load_pkt(2, 4);
    expect_next(2);
    drive();
    run(50, n);
    chk("ch2_cycles", 128'(n), 128'(5));
    load_pkt(0, 1);
    load_pkt(3, 1);
    expect_next(ord_03[0]);
    expect_next(ord_03[1]);
    drive();
    run(50, n);
    chk("ptr3_cycles", 128'(n), 128'(4));

    // Channel 0 drops valid for two cycles mid-packet
    load_pkt(0, 4);
    expect_next(0);
    drive();
    repeat (3) cycle();
    en[0] = 1'b0;
    drive();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk($sformatf("gap%0d_mvalid", i), 128'(snap_mvalid), '0);
      chk($sformatf("gap%0d_grant", i),  128'(snap_grant),  '0);
      chk($sformatf("gap%0d_busy", i),   128'(snap_busy),   128'(1));
    end
    en[0] = 1'b1;
    drive();
    run(50, n);
    chk("gap_resume_cycles", 128'(n), 128'(2));

    // Reset during beat 2 of a 5-beat packet on channel 1
    load_pkt(1, 5);
    expect_next(1);
    drive();
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    src_q[1].delete();
    exp_q.delete();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_pkt(1, 1);
    load_pkt(3, 1);
    expect_next(1);
    expect_next(3);
    drive();
    run(50, n);
    chk("post_rst_cycles", 128'(n), 128'(4));

    // All channels continuously valid with single-beat packets
    for (int c = 0; c < CN; c++) begin
      load_pkt(c, 1);
      load_pkt(c, 1);
    end
    for (int i = 0; i < 8; i++) expect_next(ord_b[i]);
    drive();
    run(100, n);
    chk("all_ch_cycles", 128'(n), 128'(16));

    // Channel 1 under backpressure with channel 3 waiting
    load_pkt(1, 3);
    load_pkt(3, 1);
    expect_next(1);
    expect_next(3);
    drive();
    s3_viol  = 0;
    s3_watch = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_ready = rp[i][0];
      cycle();
      if (i == 2) chk("stall_mvalid", 128'(snap_mvalid), 128'(1));
    end
    s3_watch = 1'b0;
    m_ready  = 1'b1;
    chk("bp_sready3", 128'(s3_viol), '0);
    chk("bp_remaining", 128'(exp_q.size()), 128'(1));
    run(50, n);
    chk("bp_ch3_cycles", 128'(n), 128'(2));

`ifdef DMA_WREQ_ARB_HIPRI_EN
    // Channel 0 preempts at every arbitration it is valid for
    load_pkt(2, 2);
    load_pkt(2, 1);
    load_pkt(0, 1);
    load_pkt(0, 1);
    expect_next(0);
    expect_next(0);
    expect_next(2);
    expect_next(2);
    drive();
    run(100, n);
    chk("hipri_cycles", 128'(n), 128'(9));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
